// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel button debouncer:
// the per-channel press FSM state and the counter-width helper.
package debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESSED,
        HELD
    } btn_fsm_e;

    // Width that holds 0..limit-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit <= 1) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce counter, press/hold FSM.
// Auto-repeat is built only when DEBOUNCE_AUTOREPEAT_EN is defined.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned HOLD_CYCLES     = 100000000,
    parameter int unsigned REPEAT_CYCLES   = 20000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic state_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o
);

    localparam int unsigned DebW  = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned HoldW = cnt_width(HOLD_CYCLES);
    localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
    logic             btn_q, btn_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    btn_fsm_e         fsm_q, fsm_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;

    // Counter holds mismatching cycles seen so far; the final one toggles instead of counting.
    always_comb begin
        deb_cnt_d = '0;
        btn_d     = btn_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sync2_q != btn_q) begin
            if (deb_cnt_q == DebLast) begin
                btn_d     = ~btn_q;
                press_d   = sync2_q;
                release_d = ~sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // Release is checked before hold completion so it wins a same-cycle tie.
    always_comb begin
        fsm_d      = fsm_q;
        hold_cnt_d = '0;
        long_d     = 1'b0;
        unique case (fsm_q)
            RELEASED: if (press_d) fsm_d = PRESSED;
            PRESSED: begin
                if (release_d) begin
                    fsm_d = RELEASED;
                end else if (hold_cnt_q == HoldLast) begin
                    fsm_d  = HELD;
                    long_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            HELD:     if (release_d) fsm_d = RELEASED;
            default:  fsm_d = RELEASED;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_cnt_q  <= '0;
            btn_q      <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
            fsm_q      <= RELEASED;
            hold_cnt_q <= '0;
        end else begin
            sync1_q    <= raw_i;
            sync2_q    <= sync1_q;
            deb_cnt_q  <= deb_cnt_d;
            btn_q      <= btn_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            fsm_q      <= fsm_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int unsigned RepW = cnt_width(REPEAT_CYCLES);
    localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_CYCLES - 1);

    logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
    logic            repeat_q, repeat_d;

    always_comb begin
        rep_cnt_d = '0;
        repeat_d  = 1'b0;
        if (fsm_q == HELD && !release_d) begin
            if (rep_cnt_q == RepLast) begin
                repeat_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rep_cnt_q <= '0;
            repeat_q  <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            repeat_q  <= repeat_d;
        end
    end

    assign repeat_o = repeat_q;
`else
    assign repeat_o = 1'b0;
`endif

    assign state_o   = btn_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule

// File: rtl/multi_button_debouncer.sv
// NUM_CH independent debounced buttons with press/release/long-press pulses.
// Define DEBOUNCE_AUTOREPEAT_EN to enable auto-repeat pulses while held.
module multi_button_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned HOLD_CYCLES     = 100000000,
    parameter int unsigned REPEAT_CYCLES   = 20000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] btn_raw,
    output logic [NUM_CH-1:0] btn_state,
    output logic [NUM_CH-1:0] press_pulse,
    output logic [NUM_CH-1:0] release_pulse,
    output logic [NUM_CH-1:0] long_pulse,
    output logic [NUM_CH-1:0] repeat_pulse
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_channel (
            .clk_i     (clk),
            .rst_i     (rst),
            .raw_i     (btn_raw[i]),
            .state_o   (btn_state[i]),
            .press_o   (press_pulse[i]),
            .release_o (release_pulse[i]),
            .long_o    (long_pulse[i]),
            .repeat_o  (repeat_pulse[i])
        );
    end

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Directed bench for multi_button_debouncer with small timing parameters.
// Repeat expectations follow DEBOUNCE_AUTOREPEAT_EN.
module tb_multi_button_debouncer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] btn_state, press_pulse, release_pulse, long_pulse, repeat_pulse;
    int         checks = 0;
    int         errors = 0;

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int ExpRep = 2;
`else
    localparam int ExpRep = 0;
`endif

    always #5 clk = ~clk;

    multi_button_debouncer #(
        .NUM_CH          (4),
        .DEBOUNCE_CYCLES (8),
        .HOLD_CYCLES     (100),
        .REPEAT_CYCLES   (20)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_raw       (btn_raw),
        .btn_state     (btn_state),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst     = 1'b1;
        btn_raw = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] any_state;
        logic [3:0] any_pulse;
        rst       = 1'b1;
        btn_raw   = 4'hF;
        any_state = '0;
        any_pulse = '0;
        for (int i = 0; i < 15; i++) begin
            step();
            any_state |= btn_state;
            any_pulse |= press_pulse | release_pulse | long_pulse | repeat_pulse;
        end
        checks++;
        if (any_state !== 4'h0) begin
            errors++;
            $display("FAIL reset_state got %h want 0", any_state);
        end
        checks++;
        if (any_pulse !== 4'h0) begin
            errors++;
            $display("FAIL reset_pulses got %h want 0", any_pulse);
        end
        apply_reset();
    endtask

    task automatic test_press();
        btn_raw[0] = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            step();
            checks++;
            if (press_pulse !== ((i == 10) ? 4'b0001 : 4'b0000)) begin
                errors++;
                $display("FAIL press_pulse cycle %0d got %b", i, press_pulse);
            end
            checks++;
            if (btn_state !== ((i >= 10) ? 4'b0001 : 4'b0000)) begin
                errors++;
                $display("FAIL press_state cycle %0d got %b", i, btn_state);
            end
        end
        apply_reset();
    endtask

    task automatic test_glitch();
        logic [3:0] seen;
        seen       = '0;
        btn_raw[1] = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (i == 7) btn_raw[1] = 1'b0;
            seen |= btn_state | press_pulse | release_pulse | long_pulse | repeat_pulse;
        end
        checks++;
        if (seen !== 4'h0) begin
            errors++;
            $display("FAIL glitch got %b want 0000", seen);
        end
        apply_reset();
    endtask

    task automatic test_long_press();
        int press_t, long_t, long_n, rep_n, rep_t0, rep_t1, rel_t;
        press_t = -1; long_t = -1; long_n = 0; rep_n = 0;
        rep_t0  = -1; rep_t1 = -1; rel_t = -1;
        btn_raw[2] = 1'b1;
        for (int i = 1; i <= 175; i++) begin
            step();
            if (press_pulse[2]) press_t = i;
            if (long_pulse[2]) begin
                long_n++;
                long_t = i;
            end
            if (repeat_pulse[2]) begin
                if (rep_n == 0) rep_t0 = i;
                else if (rep_n == 1) rep_t1 = i;
                rep_n++;
            end
            if (release_pulse[2]) rel_t = i;
            if (i == 150) btn_raw[2] = 1'b0;
        end
        checks++;
        if (press_t != 10) begin
            errors++;
            $display("FAIL long_press_time got %0d want 10", press_t);
        end
        checks++;
        if (long_n != 1 || long_t != 110) begin
            errors++;
            $display("FAIL long_pulse count %0d at %0d want 1 at 110", long_n, long_t);
        end
        checks++;
        if (rep_n != ExpRep) begin
            errors++;
            $display("FAIL repeat_count got %0d want %0d", rep_n, ExpRep);
        end
        if (ExpRep == 2) begin
            checks++;
            if (rep_t0 != 130 || rep_t1 != 150) begin
                errors++;
                $display("FAIL repeat_times got %0d,%0d want 130,150", rep_t0, rep_t1);
            end
        end
        checks++;
        if (rel_t != 160) begin
            errors++;
            $display("FAIL long_release_time got %0d want 160", rel_t);
        end
        apply_reset();
    endtask

    task automatic test_release_priority();
        int rel_t, long_n, rep_n;
        rel_t = -1; long_n = 0; rep_n = 0;
        btn_raw[0] = 1'b1;
        for (int i = 1; i <= 140; i++) begin
            step();
            if (release_pulse[0]) rel_t = i;
            if (long_pulse[0]) long_n++;
            if (repeat_pulse[0]) rep_n++;
            if (i == 100) btn_raw[0] = 1'b0;
        end
        checks++;
        if (rel_t != 110) begin
            errors++;
            $display("FAIL prio_release_time got %0d want 110", rel_t);
        end
        checks++;
        if (long_n != 0 || rep_n != 0) begin
            errors++;
            $display("FAIL prio_long got long %0d rep %0d want 0 0", long_n, rep_n);
        end
        apply_reset();
    endtask

    task automatic test_reset_mid();
        btn_raw[0] = 1'b1;
        for (int i = 0; i < 12; i++) step();
        checks++;
        if (btn_state !== 4'b0001) begin
            errors++;
            $display("FAIL mid_pre_state got %b want 0001", btn_state);
        end
        btn_raw[3] = 1'b1;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        #1;
        checks++;
        if ({btn_state, press_pulse, release_pulse, long_pulse, repeat_pulse} !== 20'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs got state %b press %b", btn_state, press_pulse);
        end
        step();
        step();
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            checks++;
            if (press_pulse !== ((i == 10) ? 4'b1001 : 4'b0000)) begin
                errors++;
                $display("FAIL mid_press cycle %0d got %b", i, press_pulse);
            end
        end
        apply_reset();
    endtask

    task automatic test_simultaneous();
        btn_raw = 4'b1111;
        for (int i = 1; i <= 12; i++) begin
            step();
            checks++;
            if (press_pulse !== ((i == 10) ? 4'b1111 : 4'b0000)) begin
                errors++;
                $display("FAIL simul_press cycle %0d got %b", i, press_pulse);
            end
        end
        btn_raw = 4'b0000;
        for (int i = 1; i <= 12; i++) begin
            step();
            checks++;
            if (release_pulse !== ((i == 10) ? 4'b1111 : 4'b0000)) begin
                errors++;
                $display("FAIL simul_release cycle %0d got %b", i, release_pulse);
            end
        end
        checks++;
        if (btn_state !== 4'b0000) begin
            errors++;
            $display("FAIL simul_state got %b want 0000", btn_state);
        end
        apply_reset();
    endtask

    initial begin
        rst     = 1'b1;
        btn_raw = '0;
        test_reset();
        test_press();
        test_glitch();
        test_long_press();
        test_release_priority();
        test_reset_mid();
        test_simultaneous();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_button_debouncer.md
MULTI_BUTTON_DEBOUNCER -- requirements
Module: multi_button_debouncer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent button channels (1..16).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles needed to accept a change (>=1).
REQ-003 SHALL have parameter HOLD_CYCLES, default 100000000: cycles pressed before long-press is flagged (>DEBOUNCE_CYCLES).
REQ-004 SHALL have parameter REPEAT_CYCLES, default 20000000: auto-repeat period after long-press (>=1).
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port btn_raw, input, NUM_CH: raw asynchronous button levels, 1 = pressed.
REQ-008 SHALL have port btn_state, output, NUM_CH: debounced level per channel.
REQ-009 SHALL have port press_pulse, output, NUM_CH: one-cycle pulse on an accepted 0->1 change.
REQ-010 SHALL have port release_pulse, output, NUM_CH: one-cycle pulse on an accepted 1->0 change.
REQ-011 SHALL have port long_pulse, output, NUM_CH: one-cycle pulse when a press reaches HOLD_CYCLES.
REQ-012 SHALL have port repeat_pulse, output, NUM_CH: one-cycle auto-repeat pulse (see Configuration).

Function
REQ-013 Each btn_raw bit SHALL pass through a 2-flop synchroniser before any other logic.
REQ-014 Per channel, a debounce counter SHALL increment each cycle the synchronised input differs from btn_state and clear to 0 on any cycle it matches.
REQ-015 When the counter would reach DEBOUNCE_CYCLES, btn_state SHALL toggle, the counter SHALL clear, and press_pulse or release_pulse SHALL assert in that same cycle.
REQ-016 Latency from a clean btn_raw edge to btn_state change SHALL be exactly 2 + DEBOUNCE_CYCLES cycles.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no state change and no pulse.
REQ-018 Per-channel FSM states: RELEASED, PRESSED, HELD; RELEASED->PRESSED on press_pulse; PRESSED->HELD after HOLD_CYCLES cycles in PRESSED; PRESSED/HELD->RELEASED on release_pulse.
REQ-019 long_pulse SHALL assert for one cycle on the PRESSED->HELD transition only, once per press.
REQ-020 A release accepted in the same cycle the hold count completes SHALL take priority: release_pulse asserts, long_pulse does not.
REQ-021 All counters SHALL be sized with clog2 of their limit and SHALL never wrap; hold/repeat counters clear on every state transition.
REQ-022 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 On rst all synchronisers, counters and btn_state SHALL clear to 0, FSMs to RELEASED, all pulse outputs to 0.
REQ-025 Reset asserted mid-debounce or mid-hold SHALL abandon the operation; after release a held button produces press_pulse 2 + DEBOUNCE_CYCLES cycles later.

Configuration
REQ-026 Macro DEBOUNCE_AUTOREPEAT_EN defined: in HELD, repeat_pulse SHALL assert for one cycle every REPEAT_CYCLES cycles, first pulse REPEAT_CYCLES cycles after long_pulse, stopping on release.
REQ-027 Macro not defined: repeat_pulse SHALL be tied to 0 and no repeat counter SHALL be synthesised.

Structure
REQ-028 Package debounce_pkg SHALL hold the FSM state enum (RELEASED, PRESSED, HELD) and the counter-width helper function.
REQ-029 Per-channel logic SHALL be sub-module debounce_channel, instantiated NUM_CH times by a generate loop; the top holds only the generate loop and port wiring.

Verification (NUM_CH=4, DEBOUNCE_CYCLES=8, HOLD_CYCLES=100, REPEAT_CYCLES=20)
REQ-030 btn_raw[0] 0->1 held -> btn_state[0]=1 and press_pulse[0] high for one cycle exactly 10 cycles after the edge.
REQ-031 btn_raw[1] pulsed high for 7 cycles -> btn_state[1] stays 0, no pulses on any channel.
REQ-032 btn_raw[2] held 150 cycles -> long_pulse[2] once at 100 cycles after press_pulse; with DEBOUNCE_AUTOREPEAT_EN, repeat_pulse[2] at +20 and +40 after long_pulse, none without the macro.
REQ-033 Release timed so release_pulse lands on the hold-complete cycle -> release_pulse only, no long_pulse.
REQ-034 rst asserted 5 cycles into a debounce on channel 3 -> all outputs 0 immediately; press_pulse[3] 10 cycles after rst deasserts.
REQ-035 btn_raw=4'b1111 in one cycle -> press_pulse=4'b1111 in one cycle, 10 cycles later.
